// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: watches a multiplexed active-low 7-segment display bus
// (digit enables an_n, segments seg_n) and recovers the hex nibble shown on
// each digit. Both buses are double-flop synchronised, each (digit, pattern)
// pair must stay stable for STABLE_CYCLES samples before it is captured, and
// completed scan frames, illegal patterns and multi-hot enables are flagged.
//
// Optional build macro SEG7_DP_EN adds a decimal-point input dp_n (part of
// the stability comparison, not of legality) and a per-digit dp output.
//
// Handshake: there is no ready; value/digit_valid are level outputs updated
// on a capture edge, and frame_done/pattern_err/an_err are single-cycle
// strobes that the consumer must sample every cycle.
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg_n,
`ifdef SEG7_DP_EN
  input  logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dp,
`endif
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    pattern_err,
  output logic                    an_err
);

  localparam logic [3:0]            STABLE = 4'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ONE    = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    HELD    = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NUM_DIGITS-1:0] an_s1, s_an, prev_an;
  logic [6:0]            seg_s1, s_seg, prev_seg;
  logic [3:0]            cnt, cnt_next;
  logic [NUM_DIGITS-1:0] mask;
  logic [NUM_DIGITS-1:0] an_low, prev_low;
  logic                  active, multi, prev_multi, same;
  logic                  capture;
  logic [3:0]            code;
  logic                  legal, blank;

`ifdef SEG7_DP_EN
  logic dp_s1, s_dp, prev_dp;

  // Decimal point travels through the same two-flop synchroniser as seg_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_s1   <= 1'b1;
      s_dp    <= 1'b1;
      prev_dp <= 1'b1;
    end else begin
      dp_s1   <= dp_n;
      s_dp    <= dp_s1;
      prev_dp <= s_dp;
    end
  end
`endif

  // Two-flop synchronisers plus a one-cycle history of the synchronised pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1    <= '1;
      s_an     <= '1;
      prev_an  <= '1;
      seg_s1   <= '1;
      s_seg    <= '1;
      prev_seg <= '1;
    end else begin
      an_s1    <= an_n;
      s_an     <= an_s1;
      prev_an  <= s_an;
      seg_s1   <= seg_n;
      s_seg    <= seg_s1;
      prev_seg <= s_seg;
    end
  end

  // Active means exactly one enable low; multi-hot is two or more low
  assign an_low     = ~s_an;
  assign prev_low   = ~prev_an;
  assign multi      = (an_low & (an_low - ONE)) != '0;
  assign active     = (an_low != '0) && !multi;
  assign prev_multi = (prev_low & (prev_low - ONE)) != '0;

`ifdef SEG7_DP_EN
  assign same = (s_an == prev_an) && (s_seg == prev_seg) && (s_dp == prev_dp);
`else
  assign same = (s_an == prev_an) && (s_seg == prev_seg);
`endif

  // Stability counter: saturating count of identical active samples
  always_comb begin
    cnt_next = 4'd0;
    if (active && same) cnt_next = (cnt == STABLE) ? cnt : cnt + 4'd1;
    else if (active)    cnt_next = 4'd1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 4'd0;
    else        cnt <= cnt_next;
  end

  // Pattern decoder: segment code (g..a, active-low) back to a nibble
  always_comb begin
    code  = 4'h0;
    legal = 1'b1;
    blank = 1'b0;
    case (s_seg)
      7'h40: code = 4'h0;
      7'h79: code = 4'h1;
      7'h24: code = 4'h2;
      7'h30: code = 4'h3;
      7'h19: code = 4'h4;
      7'h12: code = 4'h5;
      7'h02: code = 4'h6;
      7'h78: code = 4'h7;
      7'h00: code = 4'h8;
      7'h10: code = 4'h9;
      7'h08: code = 4'hA;
      7'h03: code = 4'hB;
      7'h46: code = 4'hC;
      7'h21: code = 4'hD;
      7'h06: code = 4'hE;
      7'h0E: code = 4'hF;
      7'h7F: begin legal = 1'b0; blank = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (active) state_next = QUALIFY;
      QUALIFY: begin
        if (!active)      state_next = IDLE;
        else if (capture) state_next = HELD;
      end
      HELD: begin
        if (!active)   state_next = IDLE;
        else if (!same) state_next = QUALIFY;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM output: capture on the edge the counter reaches STABLE_CYCLES
  always_comb begin
    capture = 1'b0;
    if (state == QUALIFY && active && same && cnt_next == STABLE) capture = 1'b1;
  end

  // Capture datapath, frame mask and error strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      digit_valid <= '0;
      mask        <= '0;
      frame_done  <= 1'b0;
      pattern_err <= 1'b0;
      an_err      <= 1'b0;
`ifdef SEG7_DP_EN
      dp          <= '0;
`endif
    end else begin
      // A full mask is reported one edge later and cleared on that edge;
      // a capture in the same cycle starts the next frame.
      mask        <= ((&mask) ? '0 : mask) | (capture ? an_low : '0);
      frame_done  <= &mask;
      pattern_err <= capture && !legal && !blank;
      an_err      <= multi && !prev_multi;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (capture && !s_an[k]) begin
          if (legal) begin
            value[4*k +: 4] <= code;
            digit_valid[k]  <= 1'b1;
          end else begin
            if (blank) value[4*k +: 4] <= 4'h0;
            digit_valid[k] <= 1'b0;
          end
`ifdef SEG7_DP_EN
          dp[k] <= ~s_dp;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Testbench for seg7_scan_capture: directed display-bus vectors; each
// expected output event (cycle, value, digit_valid, strobes) is queued when
// the stimulus is issued and a monitor pops and compares on every event.
module tb_seg7_scan_capture;

  localparam int ND = 4;
  localparam int W  = 39; // {cycle[15:0], value[15:0], valid[3:0], fd, pe, ae}

  logic          clk;
  logic          rst_n;
  logic [ND-1:0] an_n;
  logic [6:0]    seg_n;
  logic [4*ND-1:0] value;
  logic [ND-1:0] digit_valid;
  logic          frame_done, pattern_err, an_err;
`ifdef SEG7_DP_EN
  logic          dp_n;
  logic [ND-1:0] dp;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  logic [W-1:0] exp_q[$];

  seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .an_n(an_n),
    .seg_n(seg_n),
`ifdef SEG7_DP_EN
    .dp_n(dp_n),
    .dp(dp),
`endif
    .value(value),
    .digit_valid(digit_valid),
    .frame_done(frame_done),
    .pattern_err(pattern_err),
    .an_err(an_err)
  );

  // Clock and edge counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, queue=%0d", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic show(input logic [3:0] an, input logic [6:0] seg);
    an_n  = an;
    seg_n = seg;
    t0    = cyc;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int off, input logic [15:0] v, input logic [3:0] dv,
                           input logic fd, input logic pe, input logic ae);
    exp_q.push_back({16'(t0 + off), v, dv, fd, pe, ae});
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (value !== '0 || digit_valid !== '0 || frame_done !== 1'b0 ||
        pattern_err !== 1'b0 || an_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: value=%h valid=%b fd=%b pe=%b ae=%b, required all zero",
               name, value, digit_valid, frame_done, pattern_err, an_err);
    end
  endtask

  // Monitor / scoreboard: an event is any value/valid change or any strobe
  initial begin
    logic [19:0]  last_vv;
    logic [22:0]  obs;
    logic [W-1:0] e;
    last_vv = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_vv = '0;
      end else begin
        obs = {value, digit_valid, frame_done, pattern_err, an_err};
        if (obs[22:3] !== last_vv || obs[2:0] !== 3'b000) begin
          last_vv = obs[22:3];
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: cycle=%0d value=%h valid=%b fd=%b pe=%b ae=%b, required no event",
                     cyc, value, digit_valid, frame_done, pattern_err, an_err);
          end else begin
            e = exp_q.pop_front();
            if (e[38:23] !== 16'(cyc) || e[22:0] !== obs) begin
              errors++;
              $display("FAIL event: cycle=%0d value=%h valid=%b fd=%b pe=%b ae=%b, required cycle=%0d value=%h valid=%b fd=%b pe=%b ae=%b",
                       cyc, value, digit_valid, frame_done, pattern_err, an_err,
                       e[38:23], e[22:7], e[6:3], e[2], e[1], e[0]);
            end
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0;
    an_n  = 4'hF;
    seg_n = 7'h7F;
`ifdef SEG7_DP_EN
    dp_n  = 1'b1;
`endif
    step(3);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    step(2);

    // Single digit 0 showing 3
    show(4'b1110, 7'h30);
    expect_ev(6, 16'h0003, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(8);
    show(4'hF, 7'h7F); step(3);

    // Full scan 0,1,A,C -> one frame pulse after digit 3
    show(4'b1110, 7'h40); expect_ev(6, 16'h0000, 4'b0001, 1'b0, 1'b0, 1'b0); step(8);
    show(4'hF, 7'h7F); step(2);
    show(4'b1101, 7'h79); expect_ev(6, 16'h0010, 4'b0011, 1'b0, 1'b0, 1'b0); step(8);
    show(4'hF, 7'h7F); step(2);
    show(4'b1011, 7'h08); expect_ev(6, 16'h0A10, 4'b0111, 1'b0, 1'b0, 1'b0); step(8);
    show(4'hF, 7'h7F); step(2);
    show(4'b0111, 7'h46);
    expect_ev(6, 16'hCA10, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_ev(7, 16'hCA10, 4'b1111, 1'b1, 1'b0, 1'b0);
    step(8);
    show(4'hF, 7'h7F); step(2);

    // Unstable pattern on digit 1, then held 5
    for (int i = 0; i < 4; i++) begin
      show(4'b1101, (i % 2 == 0) ? 7'h12 : 7'h10);
      step(2);
    end
    show(4'b1101, 7'h12); expect_ev(6, 16'hCA50, 4'b1111, 1'b0, 1'b0, 1'b0); step(12);
    show(4'hF, 7'h7F); step(2);

    // Digit 2: blank, then E, then illegal 0x55
    show(4'b1011, 7'h7F); expect_ev(6, 16'hC050, 4'b1011, 1'b0, 1'b0, 1'b0); step(8);
    show(4'hF, 7'h7F); step(2);
    show(4'b1011, 7'h06); expect_ev(6, 16'hCE50, 4'b1111, 1'b0, 1'b0, 1'b0); step(8);
    show(4'hF, 7'h7F); step(2);
    show(4'b1011, 7'h55); expect_ev(6, 16'hCE50, 4'b1011, 1'b0, 1'b1, 1'b0); step(8);
    show(4'hF, 7'h7F); step(2);

    // Multi-hot enables: one an_err, no capture; then digit 1 shows 8
    show(4'b1100, 7'h30); expect_ev(3, 16'hCE50, 4'b1011, 1'b0, 1'b0, 1'b1); step(10);
    show(4'b1101, 7'h00); expect_ev(6, 16'hCE80, 4'b1011, 1'b0, 1'b0, 1'b0); step(8);
    show(4'hF, 7'h7F); step(2);

    // Complete the frame: re-capture of digit 1 must not have counted
    show(4'b1110, 7'h24); expect_ev(6, 16'hCE82, 4'b1011, 1'b0, 1'b0, 1'b0); step(8);
    show(4'hF, 7'h7F); step(2);
    show(4'b0111, 7'h21);
    expect_ev(6, 16'hDE82, 4'b1011, 1'b0, 1'b0, 1'b0);
    expect_ev(7, 16'hDE82, 4'b1011, 1'b1, 1'b0, 1'b0);
    step(8);
    show(4'hF, 7'h7F); step(2);

    // Reset during qualification, then full latency after release
    show(4'b1110, 7'h19);
    step(4);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_qual_reset");
    step(2);
    rst_n = 1'b1;
    t0 = cyc;
    expect_ev(6, 16'h0004, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
